// File: rtl/charram_dram_ctrl.sv
// Slot sequencer for one 16k x 4 character-RAM plane: interleaves video nibble
// fetches with CPU accesses in fixed 8-step slots and drives the DRAM strobes.
module charram_dram_ctrl #(
    parameter int CPU_ALT = 1
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_CEN,
    input  logic [13:0] i_VID_ADDR,
    output logic [3:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WE,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    output logic [7:0]  o_DRAM_ADDR,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n,
    output logic        o_RD_n
);

    typedef struct packed {
        logic        active;
        logic        cpu;
        logic        we;
        logic [13:0] addr;
        logic [3:0]  din;
    } slot_t;

    localparam logic [2:0] ST_LATCH = 3'd0;
    localparam logic [2:0] ST_RAS   = 3'd2;
    localparam logic [2:0] ST_CAS   = 3'd3;
    localparam logic [2:0] ST_STRB  = 3'd4;
    localparam logic [2:0] ST_REL   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_LAST  = 3'd7;

    logic [2:0] step;
    logic       odd;
    slot_t      slot;
    slot_t      nxt;

    // Even slots always belong to video; odd slots go to a requesting CPU,
    // otherwise to video or nobody depending on CPU_ALT.
    always_comb begin
        nxt        = '0;
        nxt.active = 1'b1;
        nxt.addr   = i_VID_ADDR;
        if (odd) begin
            if (i_CPU_REQ) begin
                nxt.cpu  = 1'b1;
                nxt.we   = i_CPU_WE;
                nxt.addr = i_CPU_ADDR;
                nxt.din  = i_CPU_DIN;
            end else if (CPU_ALT != 0) begin
                nxt.active = 1'b0;
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        o_VID_VALID <= 1'b0;
        o_CPU_ACK   <= 1'b0;
        if (!i_RST_n) begin
            step        <= 3'd0;
            odd         <= 1'b0;
            slot        <= '0;
            o_RAS_n     <= 1'b1;
            o_CAS_n     <= 1'b1;
            o_WR_n      <= 1'b1;
            o_RD_n      <= 1'b1;
            o_DRAM_ADDR <= 8'd0;
            o_DRAM_DIN  <= 4'd0;
            o_VID_DATA  <= 4'd0;
            o_CPU_DOUT  <= 4'd0;
        end else if (i_CEN) begin
            step <= step + 3'd1;
            if (step == ST_LAST)
                odd <= ~odd;
            case (step)
                ST_LATCH: begin
                    slot    <= nxt;
                    o_RAS_n <= 1'b1;
                    o_CAS_n <= 1'b1;
                    o_WR_n  <= 1'b1;
                    o_RD_n  <= 1'b1;
                    if (nxt.active)
                        o_DRAM_ADDR <= nxt.addr[7:0];
                end
                ST_RAS: if (slot.active) o_RAS_n <= 1'b0;
                ST_CAS: if (slot.active) begin
                    o_DRAM_ADDR <= {1'b0, slot.addr[13:8], 1'b0};
                    o_CAS_n     <= 1'b0;
                end
                ST_STRB: if (slot.active) begin
                    if (slot.cpu && slot.we) begin
                        o_WR_n     <= 1'b0;
                        o_DRAM_DIN <= slot.din;
                    end else begin
                        o_RD_n <= 1'b0;
                    end
                end
                ST_REL: begin
                    o_WR_n <= 1'b1;
                    o_RD_n <= 1'b1;
                end
                // The DRAM registers its output on the edge it first sees /RD
                // low, so the nibble is taken here, together with the pulse.
                ST_DONE: if (slot.active) begin
                    if (!slot.cpu) begin
                        o_VID_DATA  <= i_DRAM_DOUT;
                        o_VID_VALID <= 1'b1;
                    end else begin
                        if (!slot.we)
                            o_CPU_DOUT <= i_DRAM_DOUT;
                        o_CPU_ACK <= 1'b1;
                    end
                end
                ST_LAST: o_CAS_n <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench: two controllers (CPU_ALT=1 and CPU_ALT=0), each driving its own 4416 model.
module tb_charram_dram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cen, cpu_req, cpu_we;
    logic [13:0] vid_addr, cpu_addr;
    logic [3:0]  cpu_din;
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [3:0]  pre_data;

    logic [7:0] dram_addr [2];
    logic [3:0] dram_din [2];
    logic [3:0] vid_data [2];
    logic [3:0] cpu_dout [2];
    logic       vid_valid [2];
    logic       cpu_ack [2];
    logic       ras_n [2];
    logic       cas_n [2];
    logic       wr_n [2];
    logic       rd_n [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gd
            logic [3:0] mem [16384];
            logic [3:0] dout;
            logic       ras_q, cas_q;
            logic [7:0] row;
            logic [5:0] col;

            charram_dram_ctrl #(.CPU_ALT(g == 0 ? 1 : 0)) u_dut (
                .i_MCLK(clk), .i_RST_n(rst_n), .i_CEN(cen),
                .i_VID_ADDR(vid_addr), .o_VID_DATA(vid_data[g]), .o_VID_VALID(vid_valid[g]),
                .i_CPU_REQ(cpu_req), .i_CPU_WE(cpu_we), .i_CPU_ADDR(cpu_addr),
                .i_CPU_DIN(cpu_din), .o_CPU_DOUT(cpu_dout[g]), .o_CPU_ACK(cpu_ack[g]),
                .o_DRAM_ADDR(dram_addr[g]), .o_DRAM_DIN(dram_din[g]), .i_DRAM_DOUT(dout),
                .o_RAS_n(ras_n[g]), .o_CAS_n(cas_n[g]), .o_WR_n(wr_n[g]), .o_RD_n(rd_n[g])
            );

            // 4416 model: row on /RAS fall, column (bits 6:1) on /CAS fall.
            always @(posedge clk) begin
                ras_q <= ras_n[g];
                cas_q <= cas_n[g];
                if (!ras_n[g] && ras_q) row <= dram_addr[g];
                if (!cas_n[g] && cas_q) col <= dram_addr[g][6:1];
                if (!wr_n[g]) mem[{col, row}] <= dram_din[g];
                if (!rd_n[g]) dout <= mem[{col, row}];
                if (pre_we) mem[pre_addr] <= pre_data;
            end
        end
    endgenerate

    int vec = 0, errs = 0;
    int cur = 0, cen_div = 1, tk = 0;
    int nvalid, nack, nwr, valid_tk, ack_tk, first_vtk;
    logic [3:0] last_vid, last_cpu, first_vid;
    bit ack_drop;

    task automatic clr();
        tk = 0; nvalid = 0; nack = 0; nwr = 0;
        valid_tk = -1; ack_tk = -1; first_vtk = -1;
        last_vid = 4'h0; last_cpu = 4'h0; first_vid = 4'h0;
    endtask

    task automatic tick();
        cen = ((tk % cen_div) == 0);
        @(posedge clk); #1;
        if (vid_valid[cur]) begin
            if (nvalid == 0) begin first_vtk = tk; first_vid = vid_data[cur]; end
            nvalid++; valid_tk = tk; last_vid = vid_data[cur];
        end
        if (cpu_ack[cur]) begin
            nack++; ack_tk = tk; last_cpu = cpu_dout[cur];
            if (ack_drop) cpu_req = 1'b0;
        end
        if (!wr_n[cur]) nwr++;
        tk++;
    endtask

    task automatic hold_reset(input int inst);
        cur = inst; cen_div = 1; rst_n = 1'b0; cen = 1'b1; cpu_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic preload(input logic [13:0] a, input logic [3:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        clr();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1111; cpu_din = 4'hF; vid_addr = 14'h3333;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++) begin
            vec++;
            if ({ras_n[i], cas_n[i], wr_n[i], rd_n[i]} !== 4'hF) begin
                errs++; $display("FAIL reset_strobes[%0d]: got %b want 1111", i, {ras_n[i], cas_n[i], wr_n[i], rd_n[i]});
            end
            vec++;
            if (dram_addr[i] !== 8'h00) begin errs++; $display("FAIL reset_addr[%0d]: got %h want 00", i, dram_addr[i]); end
            vec++;
            if (dram_din[i] !== 4'h0) begin errs++; $display("FAIL reset_din[%0d]: got %h want 0", i, dram_din[i]); end
            vec++;
            if (vid_data[i] !== 4'h0) begin errs++; $display("FAIL reset_vid_data[%0d]: got %h want 0", i, vid_data[i]); end
            vec++;
            if (cpu_dout[i] !== 4'h0) begin errs++; $display("FAIL reset_cpu_dout[%0d]: got %h want 0", i, cpu_dout[i]); end
            vec++;
            if ({vid_valid[i], cpu_ack[i]} !== 2'b00) begin
                errs++; $display("FAIL reset_pulses[%0d]: got %b want 00", i, {vid_valid[i], cpu_ack[i]});
            end
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_video_fetch();
        int bad = 0;
        hold_reset(0);
        preload(14'h2A5C, 4'h9);
        vid_addr = 14'h2A5C; cpu_req = 1'b0; ack_drop = 1'b1;
        release_rst();
        for (int e = 0; e < 16; e++) begin
            tick();
            case (e)
                0: begin vec++; if ({ras_n[0], cas_n[0], wr_n[0], rd_n[0], dram_addr[0]} !== {4'hF, 8'h5C}) begin
                       errs++; $display("FAIL vid_row_setup: got %b/%h want 1111/5c", {ras_n[0], cas_n[0], wr_n[0], rd_n[0]}, dram_addr[0]); end end
                2: begin vec++; if ({ras_n[0], dram_addr[0]} !== {1'b0, 8'h5C}) begin
                       errs++; $display("FAIL vid_ras_fall: got ras=%b addr=%h want 0/5c", ras_n[0], dram_addr[0]); end end
                3: begin vec++; if ({cas_n[0], ras_n[0], dram_addr[0]} !== {2'b00, 8'h54}) begin
                       errs++; $display("FAIL vid_cas_fall: got cas=%b ras=%b addr=%h want 0/0/54", cas_n[0], ras_n[0], dram_addr[0]); end end
                4: begin vec++; if ({rd_n[0], wr_n[0]} !== 2'b01) begin
                       errs++; $display("FAIL vid_rd_low: got rd=%b wr=%b want 0/1", rd_n[0], wr_n[0]); end end
                5: begin vec++; if ({rd_n[0], vid_valid[0]} !== 2'b10) begin
                       errs++; $display("FAIL vid_rd_release: got rd=%b valid=%b want 1/0", rd_n[0], vid_valid[0]); end end
                6: begin vec++; if ({vid_valid[0], vid_data[0]} !== {1'b1, 4'h9}) begin
                       errs++; $display("FAIL vid_valid_data: got valid=%b data=%h want 1/9", vid_valid[0], vid_data[0]); end end
                7: begin vec++; if ({vid_valid[0], cas_n[0], ras_n[0]} !== 3'b010) begin
                       errs++; $display("FAIL vid_step7: got valid=%b cas=%b ras=%b want 0/1/0", vid_valid[0], cas_n[0], ras_n[0]); end end
                default: if (e >= 8 && {ras_n[0], cas_n[0], wr_n[0], rd_n[0]} !== 4'hF) bad++;
            endcase
        end
        vec++;
        if (bad != 0) begin errs++; $display("FAIL idle_odd_slot: got %0d active cycles want 0", bad); end
        vec++;
        if (nvalid != 1) begin errs++; $display("FAIL vid_valid_count: got %0d want 1", nvalid); end
    endtask

    task automatic test_cpu_write();
        hold_reset(0);
        preload(14'h0000, 4'h0);
        vid_addr = 14'h0000;
        release_rst();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_din = 4'hA; ack_drop = 1'b1;
        for (int e = 0; e < 32; e++) begin
            tick();
            if (e == 8) begin vec++; if ({ras_n[0], dram_addr[0]} !== {1'b1, 8'hFF}) begin
                errs++; $display("FAIL wr_row: got ras=%b addr=%h want 1/ff", ras_n[0], dram_addr[0]); end end
            if (e == 11) begin vec++; if ({cas_n[0], dram_addr[0]} !== {1'b0, 8'h7E}) begin
                errs++; $display("FAIL wr_col: got cas=%b addr=%h want 0/7e", cas_n[0], dram_addr[0]); end end
            if (e == 12) begin vec++; if ({wr_n[0], rd_n[0], dram_din[0]} !== {2'b01, 4'hA}) begin
                errs++; $display("FAIL wr_strobe: got wr=%b rd=%b din=%h want 0/1/a", wr_n[0], rd_n[0], dram_din[0]); end end
            if (e == 15) vid_addr = 14'h3FFF;
        end
        vec++;
        if (nwr != 1) begin errs++; $display("FAIL wr_width: got %0d cycles want 1", nwr); end
        vec++;
        if (nack != 1 || ack_tk != 14) begin errs++; $display("FAIL wr_ack: got %0d acks at %0d want 1 at 14", nack, ack_tk); end
        vec++;
        if (last_cpu !== 4'h0) begin errs++; $display("FAIL wr_dout_kept: got %h want 0", last_cpu); end
        vec++;
        if (valid_tk != 22 || last_vid !== 4'hA) begin
            errs++; $display("FAIL wr_readback: got %h at %0d want a at 22", last_vid, valid_tk); end
    endtask

    task automatic test_cpu_read_alt0();
        hold_reset(1);
        preload(14'h1234, 4'h5);
        preload(14'h0000, 4'h0);
        vid_addr = 14'h0000; cpu_req = 1'b0; ack_drop = 1'b1;
        release_rst();
        for (int e = 0; e < 32; e++) begin
            tick();
            if (e == 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234; end
            if (e == 8) begin vec++; if (dram_addr[1] !== 8'h34) begin
                errs++; $display("FAIL alt0_row: got %h want 34", dram_addr[1]); end end
        end
        vec++;
        if (nack != 1 || ack_tk != 14) begin errs++; $display("FAIL alt0_ack: got %0d acks at %0d want 1 at 14", nack, ack_tk); end
        vec++;
        if (last_cpu !== 4'h5) begin errs++; $display("FAIL alt0_dout: got %h want 5", last_cpu); end
        vec++;
        if (nvalid != 3 || valid_tk != 30) begin
            errs++; $display("FAIL alt0_video_fill: got %0d valids last at %0d want 3 last at 30", nvalid, valid_tk); end
    endtask

    task automatic test_cen_stretch();
        hold_reset(0);
        preload(14'h2A5C, 4'h9);
        vid_addr = 14'h2A5C;
        release_rst();
        cen_div = 3;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0155; cpu_din = 4'h3; ack_drop = 1'b1;
        for (int e = 0; e < 72; e++) begin
            tick();
            if (e == 1) vid_addr = 14'h0155;
        end
        cen_div = 1;
        vec++;
        if (first_vtk != 18 || first_vid !== 4'h9) begin
            errs++; $display("FAIL cen_first_valid: got %h at %0d want 9 at 18", first_vid, first_vtk); end
        vec++;
        if (nvalid != 2) begin errs++; $display("FAIL cen_valid_width: got %0d valid cycles want 2", nvalid); end
        vec++;
        if (nack != 1 || ack_tk != 42) begin errs++; $display("FAIL cen_ack: got %0d ack cycles at %0d want 1 at 42", nack, ack_tk); end
        vec++;
        if (nwr != 3) begin errs++; $display("FAIL cen_wr_stretch: got %0d want 3", nwr); end
        vec++;
        if (valid_tk != 66 || last_vid !== 4'h3) begin
            errs++; $display("FAIL cen_readback: got %h at %0d want 3 at 66", last_vid, valid_tk); end
    endtask

    task automatic test_reset_mid_write();
        hold_reset(0);
        preload(14'h0777, 4'h6);
        preload(14'h0000, 4'h0);
        vid_addr = 14'h0000;
        release_rst();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0777; cpu_din = 4'hC; ack_drop = 1'b0;
        for (int e = 0; e < 13; e++) tick();
        vec++;
        if (wr_n[0] !== 1'b0) begin errs++; $display("FAIL rst_wr_pre: got wr=%b want 0", wr_n[0]); end
        rst_n = 1'b0;
        tick();
        vec++;
        if ({ras_n[0], cas_n[0], wr_n[0], rd_n[0], cpu_ack[0]} !== 5'b11110) begin
            errs++; $display("FAIL rst_abort: got %b want 11110", {ras_n[0], cas_n[0], wr_n[0], rd_n[0], cpu_ack[0]}); end
        vec++;
        if (nack != 0) begin errs++; $display("FAIL rst_no_ack: got %0d want 0", nack); end
        cpu_we = 1'b0; vid_addr = 14'h0777; ack_drop = 1'b1;
        release_rst();
        for (int e = 0; e < 16; e++) tick();
        vec++;
        if (valid_tk != 6 || last_vid !== 4'hC) begin
            errs++; $display("FAIL rst_even_restart: got %h at %0d want c at 6", last_vid, valid_tk); end
        vec++;
        if (nack != 1 || ack_tk != 14 || last_cpu !== 4'hC) begin
            errs++; $display("FAIL rst_odd_read: got %0d acks at %0d data %h want 1 at 14 data c", nack, ack_tk, last_cpu); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        hold_reset(0);
        preload(14'h2A5C, 4'h9);
        vid_addr = 14'h2A5C;
        release_rst();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2A5C; ack_drop = 1'b0;
        for (int e = 0; e < 128; e++) begin
            tick();
            if (cpu_ack[0] && (e % 16) != 14) bad++;
            if (vid_valid[0] && (e % 16) != 6) bad++;
        end
        cpu_req = 1'b0;
        vec++;
        if (bad != 0) begin errs++; $display("FAIL b2b_alternation: got %0d misplaced pulses want 0", bad); end
        vec++;
        if (nack != 8) begin errs++; $display("FAIL b2b_acks: got %0d want 8", nack); end
        vec++;
        if (nvalid != 8) begin errs++; $display("FAIL b2b_valids: got %0d want 8", nvalid); end
        vec++;
        if (last_cpu !== 4'h9) begin errs++; $display("FAIL b2b_dout: got %h want 9", last_cpu); end
    endtask

    initial begin
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        rst_n = 1'b0; cen = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_din = '0; vid_addr = '0; ack_drop = 1'b1;
        clr();
        test_reset();
        test_video_fetch();
        test_cpu_write();
        test_cpu_read_alt0();
        test_cen_stretch();
        test_reset_mid_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
